// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//
// Turns a raw, asynchronous key pin into a clean debounced level plus
// single-cycle press / release / long-press events and a press counter.
//
// Optional feature macro: KEY_LONG_PRESS_EN
//   defined   -> hold counter and HELD state are built, long_o pulses once
//                per press after LONG_CYCLES edges of continuous hold.
//   undefined -> no hold counter, no HELD state, long_o tied to 0 and
//                LONG_CYCLES only takes part in the parameter range check.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable cycles needed to accept a change (>=1)
//   LONG_CYCLES     : hold cycles before the long-press event (>=1)
//   INVERT          : 1 when the key pin is active-low
//
// Ports
//   clk       in   fabric clock
//   rst       in   asynchronous active-high reset
//   key_i     in   raw key pin, asynchronous to clk
//   key_o     out  debounced level, 1 = pressed
//   press_o   out  one-cycle pulse on an accepted press
//   release_o out  one-cycle pulse on an accepted release
//   long_o    out  one-cycle pulse when a hold reaches LONG_CYCLES
//   count_o   out  accepted presses modulo 256
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned LONG_CYCLES     = 4194304,
    parameter bit          INVERT          = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_i,
    output logic       key_o,
    output logic       press_o,
    output logic       release_o,
    output logic       long_o,
    output logic [7:0] count_o
);

    localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Reject illegal parameterisations at elaboration time.
    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } state_t;
`endif

    // Registers
    logic            r_sync1;
    logic            r_sync2;
    logic [DB_W-1:0] r_db_cnt;
    state_t          r_state;
    logic            r_key;
    logic            r_press;
    logic            r_release;
    logic [7:0]      r_count;

    // Combinational next values
    logic            w_k;
    logic            w_diff;
    logic            w_accept;
    state_t          w_state_nxt;
    logic            w_key_nxt;
    logic            w_press_nxt;
    logic            w_release_nxt;
    logic [7:0]      w_count_nxt;

`ifdef KEY_LONG_PRESS_EN
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_long;
    logic              w_long_nxt;
`endif

    // Polarity correction ahead of the synchroniser.
    assign w_k = key_i ^ INVERT;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= w_k;
            r_sync2 <= r_sync1;
        end
    end

    // A change is accepted on the edge where the disagreement has already
    // been seen for DEBOUNCE_CYCLES-1 edges; any agreement restarts the count.
    assign w_diff   = (r_sync2 != r_key);
    assign w_accept = w_diff && (r_db_cnt == DB_LAST);

    // Debounce counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_cnt <= '0;
        end else if (!w_diff || w_accept) begin
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
        end
    end

`ifdef KEY_LONG_PRESS_EN
    // Hold counter: held at zero while released so it starts from zero on
    // entry to PRESSED, counts in PRESSED, freezes in HELD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_RELEASED) begin
            r_hold_cnt <= '0;
        end else if (r_state == ST_PRESSED) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end
`endif

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_RELEASED;
            r_key     <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_count   <= 8'd0;
`ifdef KEY_LONG_PRESS_EN
            r_long    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_key     <= w_key_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_count   <= w_count_nxt;
`ifdef KEY_LONG_PRESS_EN
            r_long    <= w_long_nxt;
`endif
        end
    end

    // Next-state and next-output logic. A release takes priority over the
    // long-press transition so long_o never coincides with release_o.
    always_comb begin
        w_state_nxt   = r_state;
        w_key_nxt     = r_key;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_count_nxt   = r_count;
`ifdef KEY_LONG_PRESS_EN
        w_long_nxt    = 1'b0;
`endif

        if (w_accept) begin
            w_key_nxt = r_sync2;
        end

        case (r_state)
            ST_RELEASED: begin
                if (w_accept && r_sync2) begin
                    w_state_nxt = ST_PRESSED;
                    w_press_nxt = 1'b1;
                    w_count_nxt = r_count + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (w_accept && !r_sync2) begin
                    w_state_nxt   = ST_RELEASED;
                    w_release_nxt = 1'b1;
                end
`ifdef KEY_LONG_PRESS_EN
                else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_long_nxt  = 1'b1;
                end
`endif
            end
`ifdef KEY_LONG_PRESS_EN
            ST_HELD: begin
                if (w_accept && !r_sync2) begin
                    w_state_nxt   = ST_RELEASED;
                    w_release_nxt = 1'b1;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_RELEASED;
            end
        endcase
    end

    assign key_o     = r_key;
    assign press_o   = r_press;
    assign release_o = r_release;
    assign count_o   = r_count;
`ifdef KEY_LONG_PRESS_EN
    assign long_o    = r_long;
`else
    assign long_o    = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//
// Bench for key_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20. A second
// instance uses INVERT=1. Expected event edges are queued when stimulus is
// driven and consumed when the matching pulse is observed; level and counter
// values are checked at the end of each stimulus segment.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int unsigned DB   = 4;
    localparam int unsigned LONG = 20;
    localparam int          LAT  = DB + 2;
`ifdef KEY_LONG_PRESS_EN
    localparam int          LONG_EN = 1;
`else
    localparam int          LONG_EN = 0;
`endif

    typedef struct {
        int level;
        int cycles;
        int accept;
        int long_ev;
        int exp_key;
        int exp_count;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key = 1'b0;
    logic       key_inv = 1'b1;

    logic       key_o, press_o, release_o, long_o;
    logic [7:0] count_o;
    logic       inv_key_o, inv_press_o, inv_release_o, inv_long_o;
    logic [7:0] inv_count_o;

    int n_checks = 0;
    int n_errors = 0;
    int edge_cnt = 0;

    int press_q[$];
    int release_q[$];
    int long_q[$];
    int inv_press_q[$];
    int inv_release_q[$];
    int inv_long_q[$];

    vec_t vecs[$];

    key_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LONG),
        .INVERT         (1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_i    (key),
        .key_o    (key_o),
        .press_o  (press_o),
        .release_o(release_o),
        .long_o   (long_o),
        .count_o  (count_o)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES(DB),
        .LONG_CYCLES    (LONG),
        .INVERT         (1'b1)
    ) dut_inv (
        .clk      (clk),
        .rst      (rst),
        .key_i    (key_inv),
        .key_o    (inv_key_o),
        .press_o  (inv_press_o),
        .release_o(inv_release_o),
        .long_o   (inv_long_o),
        .count_o  (inv_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Match an observed pulse against the queued expected edge numbers.
    task automatic ev_check(input string name, input logic pulse, ref int q[$]);
        while (q.size() > 0 && q[0] < edge_cnt) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s missed: no pulse, expected at edge %0d", name, q[0]);
            void'(q.pop_front());
        end
        if (pulse) begin
            n_checks++;
            if (q.size() > 0 && q[0] == edge_cnt) begin
                void'(q.pop_front());
            end else begin
                n_errors++;
                $display("FAIL %s unexpected: pulse at edge %0d, expected edge %0d",
                         name, edge_cnt, (q.size() > 0) ? q[0] : -1);
            end
        end
    endtask

    // One clock: count the edge, then sample on the falling edge.
    task automatic cyc();
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        if (!rst) begin
            ev_check("press",       press_o,       press_q);
            ev_check("release",     release_o,     release_q);
            ev_check("long",        long_o,        long_q);
            ev_check("inv_press",   inv_press_o,   inv_press_q);
            ev_check("inv_release", inv_release_o, inv_release_q);
            ev_check("inv_long",    inv_long_o,    inv_long_q);
            if (32'(press_o) + 32'(release_o) + 32'(long_o) > 1) begin
                check("one_event", 32'(press_o) + 32'(release_o) + 32'(long_o), 1);
            end
        end
    endtask

    // Hold a level for v.cycles edges; queue the events it must produce.
    task automatic seg(input vec_t v, input string tag);
        int e;
        key = v.level[0];
        e   = edge_cnt;
        if (v.accept != 0) begin
            if (v.level != 0) press_q.push_back(e + LAT);
            else              release_q.push_back(e + LAT);
        end
        if (v.long_ev != 0) long_q.push_back(e + LAT + int'(LONG));
        repeat (v.cycles) cyc();
        check({tag, " key_o"},   32'(key_o),   v.exp_key);
        check({tag, " count_o"}, 32'(count_o), v.exp_count);
    endtask

    initial begin
        int c;
        int e;

        // level, cycles, accept, long, key after, count after
        vecs.push_back('{0,  8, 0, 0,       0, 0});  // idle
        vecs.push_back('{1, 10, 1, 0,       1, 1});  // clean press
        vecs.push_back('{0, 10, 1, 0,       0, 1});  // release
        vecs.push_back('{1,  3, 0, 0,       0, 1});  // bounce high 3
        vecs.push_back('{0,  1, 0, 0,       0, 1});  // bounce low 1
        vecs.push_back('{1,  3, 0, 0,       0, 1});  // bounce high 3
        vecs.push_back('{0, 10, 0, 0,       0, 1});  // settle low
        vecs.push_back('{1,  4, 1, 0,       0, 1});  // minimal stable high
        vecs.push_back('{0, 10, 1, 0,       0, 2});  // press lands, then release
        vecs.push_back('{1, 40, 1, LONG_EN, 1, 3});  // long hold
        vecs.push_back('{0, 10, 1, 0,       0, 3});  // release after long

        // Reset state
        repeat (3) cyc();
        check("rst key_o",     32'(key_o),     0);
        check("rst press_o",   32'(press_o),   0);
        check("rst release_o", 32'(release_o), 0);
        check("rst long_o",    32'(long_o),    0);
        check("rst count_o",   32'(count_o),   0);
        check("rst inv_key_o", 32'(inv_key_o), 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            seg(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-debounce of a press, key kept high
        key = 1'b1;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        check("async key_o",     32'(key_o),     0);
        check("async press_o",   32'(press_o),   0);
        check("async release_o", 32'(release_o), 0);
        check("async long_o",    32'(long_o),    0);
        check("async count_o",   32'(count_o),   0);
        repeat (3) cyc();
        rst = 1'b0;
        e   = edge_cnt;
        press_q.push_back(e + LAT);
        repeat (10) cyc();
        check("post_rst key_o",   32'(key_o),   1);
        check("post_rst count_o", 32'(count_o), 1);

        // Reset mid-hold: level drops at once, nothing on exit
        #2 rst = 1'b1;
        #1;
        check("hold_rst key_o",   32'(key_o),   0);
        check("hold_rst count_o", 32'(count_o), 0);
        key = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (10) cyc();
        check("hold_rst exit key_o", 32'(key_o), 0);

        // 256 clean presses wrap the counter
        c = 0;
        for (int i = 0; i < 256; i++) begin
            c = (c + 1) % 256;
            seg('{1, 8, 1, 0, 1, c}, $sformatf("wrap%0d hi", i));
            seg('{0, 8, 1, 0, 0, c}, $sformatf("wrap%0d lo", i));
        end
        check("wrap_final count_o", 32'(count_o), 0);

        // Active-low pin on the inverting instance
        key_inv = 1'b0;
        e       = edge_cnt;
        inv_press_q.push_back(e + LAT);
        if (LONG_EN != 0) inv_long_q.push_back(e + LAT + int'(LONG));
        repeat (40) cyc();
        check("inv key_o",   32'(inv_key_o),   1);
        check("inv count_o", 32'(inv_count_o), 1);
        key_inv = 1'b1;
        e       = edge_cnt;
        inv_release_q.push_back(e + LAT);
        repeat (10) cyc();
        check("inv rel key_o", 32'(inv_key_o), 0);

        // Every queued event must have been seen
        check("press_q left",       press_q.size(),       0);
        check("release_q left",     release_q.size(),     0);
        check("long_q left",        long_q.size(),        0);
        check("inv_press_q left",   inv_press_q.size(),   0);
        check("inv_release_q left", inv_release_q.size(), 0);
        check("inv_long_q left",    inv_long_q.size(),    0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
